// File: rtl/noc_switch_allocator_if.sv
// Switch-allocator bundle: input-buffer head signals, downstream ready,
// grants, output valids and the five crossbar port selects.
// Optional NOC_ALLOC_WATCHDOG_EN adds the per-output alloc_timeout pulse.
interface noc_switch_allocator_if;
   logic [4:0]  in_req;
   logic [14:0] in_dest;
   logic [4:0]  in_tail;
   logic [4:0]  out_ready;
   logic [4:0]  in_gnt;
   logic [4:0]  out_valid;
   logic [2:0]  N_port_select;
   logic [2:0]  S_port_select;
   logic [2:0]  E_port_select;
   logic [2:0]  W_port_select;
   logic [2:0]  L_port_select;
`ifdef NOC_ALLOC_WATCHDOG_EN
   logic [4:0]  alloc_timeout;
`endif

   modport master (
      output in_req, in_dest, in_tail, out_ready,
      input  in_gnt, out_valid,
      input  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select
`ifdef NOC_ALLOC_WATCHDOG_EN
      , input alloc_timeout
`endif
   );

   modport slave (
      input  in_req, in_dest, in_tail, out_ready,
      output in_gnt, out_valid,
      output N_port_select, S_port_select, E_port_select, W_port_select, L_port_select
`ifdef NOC_ALLOC_WATCHDOG_EN
      , output alloc_timeout
`endif
   );
endinterface

// File: rtl/noc_switch_allocator.sv
// 5-port NoC switch allocator: per-output round-robin arbitration with
// wormhole locking from head to tail. Ports N=0,S=1,E=2,W=3,L=4.
// Optional NOC_ALLOC_WATCHDOG_EN: forced unlock after TIMEOUT_CYCLES
// locked cycles in which the owner presents no flit.
module noc_switch_allocator #(
   parameter logic [2:0]  PTR_RESET      = 3'd0,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TIMEOUT_W      = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   noc_switch_allocator_if.slave  bus
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t     r_state [5];
   state_t     w_state_nxt [5];
   logic [2:0] r_owner [5];
   logic [2:0] w_owner_nxt [5];
   logic [2:0] r_ptr [5];
   logic [2:0] w_ptr_nxt [5];
   logic [2:0] w_dest [5];
   logic [2:0] w_pick [5];
   logic [2:0] w_sel [5];
   logic [4:0] w_any;
   logic [4:0] w_xfer;
   logic [4:0] w_gnt;
`ifdef NOC_ALLOC_WATCHDOG_EN
   logic [TIMEOUT_W-1:0] r_wd [5];
   logic [TIMEOUT_W-1:0] w_wd_nxt [5];
   logic [4:0]           r_timeout;
   logic [4:0]           w_timeout_nxt;
`endif

   function automatic logic [2:0] f_inc5(input logic [2:0] x);
      return (x >= 3'd4) ? 3'd0 : x + 3'd1;
   endfunction

   // Unpack per-input destination fields.
   always_comb begin
      for (int unsigned p = 0; p < 5; p++) begin
         w_dest[p] = bus.in_dest[3*p +: 3];
      end
   end

   // Round-robin pick per output: first eligible input scanning from ptr.
   always_comb begin
      logic [2:0] w_idx;
      for (int unsigned o = 0; o < 5; o++) begin
         w_any[o]  = 1'b0;
         w_pick[o] = 3'(o);
         w_idx     = r_ptr[o];
         for (int unsigned i = 0; i < 5; i++) begin
            if (!w_any[o] && (w_idx < 3'd5) && bus.in_req[w_idx] &&
                (w_dest[w_idx] == 3'(o)) && (w_idx != 3'(o))) begin
               w_any[o]  = 1'b1;
               w_pick[o] = w_idx;
            end
            w_idx = f_inc5(w_idx);
         end
      end
   end

   // Locked outputs steer the crossbar and transfer when owner flit and ready line up.
   always_comb begin
      w_gnt = '0;
      for (int unsigned o = 0; o < 5; o++) begin
         w_xfer[o] = 1'b0;
         w_sel[o]  = 3'(o);
         if (r_state[o] == ST_LOCKED) begin
            w_sel[o] = r_owner[o];
            if (bus.in_req[r_owner[o]] && (w_dest[r_owner[o]] == 3'(o)) &&
                bus.out_ready[o]) begin
               w_xfer[o]           = 1'b1;
               w_gnt[r_owner[o]]   = 1'b1;
            end
         end
      end
   end

   // Per-output next state: lock on arbitration win, release on tail (or watchdog).
   always_comb begin
`ifdef NOC_ALLOC_WATCHDOG_EN
      w_timeout_nxt = '0;
`endif
      for (int unsigned o = 0; o < 5; o++) begin
         w_state_nxt[o] = r_state[o];
         w_owner_nxt[o] = r_owner[o];
         w_ptr_nxt[o]   = r_ptr[o];
`ifdef NOC_ALLOC_WATCHDOG_EN
         w_wd_nxt[o]    = r_wd[o];
`endif
         case (r_state[o])
            ST_IDLE: begin
               if (w_any[o]) begin
                  w_state_nxt[o] = ST_LOCKED;
                  w_owner_nxt[o] = w_pick[o];
`ifdef NOC_ALLOC_WATCHDOG_EN
                  w_wd_nxt[o]    = '0;
`endif
               end
            end
            ST_LOCKED: begin
               if (w_xfer[o]) begin
`ifdef NOC_ALLOC_WATCHDOG_EN
                  w_wd_nxt[o] = '0;
`endif
                  if (bus.in_tail[r_owner[o]]) begin
                     w_state_nxt[o] = ST_IDLE;
                     w_ptr_nxt[o]   = f_inc5(r_owner[o]);
                  end
               end
`ifdef NOC_ALLOC_WATCHDOG_EN
               else if (!bus.in_req[r_owner[o]]) begin
                  if (r_wd[o] == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                     w_state_nxt[o]   = ST_IDLE;
                     w_ptr_nxt[o]     = f_inc5(r_owner[o]);
                     w_wd_nxt[o]      = '0;
                     w_timeout_nxt[o] = 1'b1;
                  end else begin
                     w_wd_nxt[o] = r_wd[o] + TIMEOUT_W'(1);
                  end
               end
`endif
            end
            default: w_state_nxt[o] = ST_IDLE;
         endcase
      end
   end

   // State registers; reset drops every lock immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned o = 0; o < 5; o++) begin
            r_state[o] <= ST_IDLE;
            r_owner[o] <= 3'(o);
            r_ptr[o]   <= PTR_RESET;
`ifdef NOC_ALLOC_WATCHDOG_EN
            r_wd[o]    <= '0;
`endif
         end
`ifdef NOC_ALLOC_WATCHDOG_EN
         r_timeout <= '0;
`endif
      end else begin
         for (int unsigned o = 0; o < 5; o++) begin
            r_state[o] <= w_state_nxt[o];
            r_owner[o] <= w_owner_nxt[o];
            r_ptr[o]   <= w_ptr_nxt[o];
`ifdef NOC_ALLOC_WATCHDOG_EN
            r_wd[o]    <= w_wd_nxt[o];
`endif
         end
`ifdef NOC_ALLOC_WATCHDOG_EN
         r_timeout <= w_timeout_nxt;
`endif
      end
   end

   assign bus.in_gnt        = w_gnt;
   assign bus.out_valid     = w_xfer;
   assign bus.N_port_select = w_sel[0];
   assign bus.S_port_select = w_sel[1];
   assign bus.E_port_select = w_sel[2];
   assign bus.W_port_select = w_sel[3];
   assign bus.L_port_select = w_sel[4];
`ifdef NOC_ALLOC_WATCHDOG_EN
   assign bus.alloc_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Bench for noc_switch_allocator: packet sources per input, scoreboard of
// expected (output, input) flit crossings checked whenever a flit crosses.
module tb_noc_switch_allocator;

   typedef struct packed {
      logic [2:0] out_idx;
      logic [2:0] in_idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t q_exp[$];

   int         rem [5];
   logic [2:0] dst [5];
   logic [4:0] s_gnt;
   logic [4:0] s_valid;
   logic [2:0] s_sel [5];
   logic [2:0] t_sel [5];
   logic [4:0] m_gnt;
   exp_t       m_e;
`ifdef NOC_ALLOC_WATCHDOG_EN
   logic [4:0] s_to;
`endif

   noc_switch_allocator_if bus();

   noc_switch_allocator #(
      .PTR_RESET(3'd0),
      .TIMEOUT_CYCLES(16),
      .TIMEOUT_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign t_sel[0] = bus.N_port_select;
   assign t_sel[1] = bus.S_port_select;
   assign t_sel[2] = bus.E_port_select;
   assign t_sel[3] = bus.W_port_select;
   assign t_sel[4] = bus.L_port_select;

   // Scoreboard: every crossing flit must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && (bus.out_valid != 5'd0 || bus.in_gnt != 5'd0)) begin
         m_gnt = '0;
         for (int o = 0; o < 5; o++) begin
            if (bus.out_valid[o]) begin
               checks++;
               if (q_exp.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected out=%0d sel=%0d required none", o, t_sel[o]);
               end else begin
                  m_e = q_exp.pop_front();
                  if (m_e.out_idx != 3'(o) || t_sel[o] !== m_e.in_idx) begin
                     errors++;
                     $display("FAIL sb_flit got out=%0d sel=%0d required out=%0d sel=%0d",
                              o, t_sel[o], m_e.out_idx, m_e.in_idx);
                  end
                  m_gnt[m_e.in_idx] = 1'b1;
               end
            end
         end
         checks++;
         if (bus.in_gnt !== m_gnt) begin
            errors++;
            $display("FAIL sb_gnt got %b required %b", bus.in_gnt, m_gnt);
         end
      end
   end

   task automatic apply();
      for (int p = 0; p < 5; p++) begin
         bus.in_req[p]          = (rem[p] > 0);
         bus.in_tail[p]         = (rem[p] == 1);
         bus.in_dest[3*p +: 3]  = dst[p];
      end
   endtask

   task automatic load(input int p, input int d, input int n, input int npush);
      exp_t e;
      rem[p] = n;
      dst[p] = 3'(d);
      for (int i = 0; i < npush; i++) begin
         e.out_idx = 3'(d);
         e.in_idx  = 3'(p);
         q_exp.push_back(e);
      end
      apply();
   endtask

   task automatic run_cycle();
      @(negedge clk);
      s_gnt   = bus.in_gnt;
      s_valid = bus.out_valid;
      for (int o = 0; o < 5; o++) s_sel[o] = t_sel[o];
`ifdef NOC_ALLOC_WATCHDOG_EN
      s_to = bus.alloc_timeout;
`endif
      @(posedge clk);
      #1;
      for (int p = 0; p < 5; p++) if (s_gnt[p] && rem[p] > 0) rem[p]--;
      apply();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < 5; p++) begin
         rem[p] = 0;
         dst[p] = 3'd0;
      end
      apply();
      bus.out_ready = '1;
      q_exp.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (q_exp.size() != 0) begin
         errors++;
         $display("FAIL %s_drained got %0d pending flits required 0", name, q_exp.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.in_gnt !== 5'd0 || bus.out_valid !== 5'd0) begin
         errors++;
         $display("FAIL reset_init got gnt=%b valid=%b required 0", bus.in_gnt, bus.out_valid);
      end
      load(4, 0, 3, 1);
      run_cycle();
      run_cycle();
      checks++;
      if (s_sel[0] !== 3'd4 || s_gnt !== 5'b10000) begin
         errors++;
         $display("FAIL reset_prelock got sel=%0d gnt=%b required 4 10000", s_sel[0], s_gnt);
      end
      rst = 1'b1;
      #1;
      for (int o = 0; o < 5; o++) begin
         checks++;
         if (t_sel[o] !== 3'(o)) begin
            errors++;
            $display("FAIL reset_sel%0d got %0d required %0d", o, t_sel[o], o);
         end
      end
      checks++;
      if (bus.in_gnt !== 5'd0 || bus.out_valid !== 5'd0) begin
         errors++;
         $display("FAIL reset_async got gnt=%b valid=%b required 0", bus.in_gnt, bus.out_valid);
      end
      check_drained("reset");
      do_reset();
   endtask

   task automatic test_single_flit();
      do_reset();
      load(4, 2, 1, 1);
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         checks++;
         if (c == 1) begin
            if (s_sel[2] !== 3'd4 || s_gnt !== 5'b10000) begin
               errors++;
               $display("FAIL single_c1 got sel=%0d gnt=%b required 4 10000", s_sel[2], s_gnt);
            end
         end else if (s_sel[2] !== 3'd2 || s_gnt !== 5'b00000) begin
            errors++;
            $display("FAIL single_c%0d got sel=%0d gnt=%b required 2 00000", c, s_sel[2], s_gnt);
         end
      end
      check_drained("single");
   endtask

   task automatic test_contention();
      int first [5];
      do_reset();
      for (int p = 0; p < 5; p++) first[p] = -1;
      load(1, 0, 3, 3);
      load(3, 0, 3, 3);
      load(4, 0, 3, 3);
      for (int c = 0; c < 14; c++) begin
         run_cycle();
         for (int p = 0; p < 5; p++) if (s_gnt[p] && first[p] < 0) first[p] = c;
      end
      checks++;
      if (first[1] != 1 || first[3] != 5 || first[4] != 9) begin
         errors++;
         $display("FAIL contention_order got S=%0d W=%0d L=%0d required 1 5 9",
                  first[1], first[3], first[4]);
      end
      check_drained("contention");
   endtask

   task automatic test_stall();
      int ngnt = 0;
      do_reset();
      load(0, 4, 4, 4);
      for (int c = 0; c < 12; c++) begin
         bus.out_ready[4] = !(c >= 2 && c <= 4);
         if (c == 1) load(1, 4, 1, 1);
         run_cycle();
         if (s_gnt[0]) ngnt++;
         if (c >= 2 && c <= 4) begin
            checks++;
            if (s_gnt[0] !== 1'b0 || s_sel[4] !== 3'd0) begin
               errors++;
               $display("FAIL stall_c%0d got gnt=%b sel=%0d required 0 0", c, s_gnt, s_sel[4]);
            end
         end
      end
      checks++;
      if (ngnt != 4) begin
         errors++;
         $display("FAIL stall_count got %0d required 4", ngnt);
      end
      check_drained("stall");
   endtask

   task automatic test_illegal();
      do_reset();
      rem[2] = 1; dst[2] = 3'd2;
      rem[3] = 1; dst[3] = 3'd7;
      apply();
      for (int c = 0; c < 8; c++) begin
         run_cycle();
         checks++;
         if (s_gnt !== 5'd0 || s_valid !== 5'd0 || s_sel[2] !== 3'd2 || s_sel[3] !== 3'd3) begin
            errors++;
            $display("FAIL illegal_c%0d got gnt=%b valid=%b selE=%0d selW=%0d required 0 0 2 3",
                     c, s_gnt, s_valid, s_sel[2], s_sel[3]);
         end
      end
      do_reset();
   endtask

   task automatic test_parallel();
      do_reset();
      load(0, 1, 1, 1);
      load(2, 3, 1, 1);
      run_cycle();
      checks++;
      if (s_gnt !== 5'd0) begin
         errors++;
         $display("FAIL parallel_c0 got gnt=%b required 00000", s_gnt);
      end
      run_cycle();
      checks++;
      if (s_gnt !== 5'b00101 || s_sel[1] !== 3'd0 || s_sel[3] !== 3'd2) begin
         errors++;
         $display("FAIL parallel_c1 got gnt=%b selS=%0d selW=%0d required 00101 0 2",
                  s_gnt, s_sel[1], s_sel[3]);
      end
      run_cycle();
      checks++;
      if (s_gnt !== 5'd0) begin
         errors++;
         $display("FAIL parallel_c2 got gnt=%b required 00000", s_gnt);
      end
      check_drained("parallel");
   endtask

`ifdef NOC_ALLOC_WATCHDOG_EN
   task automatic test_watchdog();
      int seen = -1;
      do_reset();
      load(4, 2, 3, 1);
      run_cycle();
      run_cycle();
      rem[4] = 0;
      apply();
      for (int c = 2; c < 40; c++) begin
         run_cycle();
         if (s_to[2] && seen < 0) begin
            seen = c;
            checks++;
            if (s_sel[2] !== 3'd2) begin
               errors++;
               $display("FAIL watchdog_idle got sel=%0d required 2", s_sel[2]);
            end
         end
      end
      checks++;
      if (seen != 18) begin
         errors++;
         $display("FAIL watchdog_pulse got cycle %0d required 18", seen);
      end
      check_drained("watchdog");
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.out_ready = '1;
      test_reset();
      test_single_flit();
      test_contention();
      test_stall();
      test_illegal();
      test_parallel();
`ifdef NOC_ALLOC_WATCHDOG_EN
      test_watchdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
